debounce_bank: RTL

- Parametrised multi-channel debouncer for elevator call/floor buttons, door sensors and the external reset button.
- Each channel has a synchroniser, a per-channel stability counter, a debounced level output, one-cycle rise/fall pulses and an optional one-shot long-press pulse.
- An optional tick input sets the counting rate.
- Sits between the board pins and the elevator controller FSM.

---
 rtl/debounce_pkg.sv | 15 +
 rtl/debounce_ch.sv | 96 +++++++++
 rtl/debounce_bank.sv | 54 +++++
 3 files changed

// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the debounce bank.
// Provides default parameter values and counter width helper.
package debounce_pkg;

   localparam int DB_CYCLES_DEF   = 1000;
   localparam int SYNC_STAGES_DEF = 2;

   // Width of a counter holding 0..v-1, never below one bit.
   function automatic int clog2_min1(input int v);
      int w;
      w = $clog2(v);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/debounce_ch.sv
// One debounce channel: synchroniser, stability counter, hold counter.
// Ports: clk, rst, tick, raw -> db, rise_p, fall_p, long_p, rise_nxt.
module debounce_ch
   import debounce_pkg::*;
#(
   parameter int   DB_CYCLES   = DB_CYCLES_DEF,
   parameter int   SYNC_STAGES = SYNC_STAGES_DEF,
   parameter int   LONG_CYCLES = 0,
   parameter logic RST_LEVEL   = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic tick,
   input  logic raw,
   output logic db,
   output logic rise_p,
   output logic fall_p,
   output logic long_p,
   output logic rise_nxt
);

   localparam int CNT_W = clog2_min1(DB_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST =
      CNT_W'(DB_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync;
   logic                   s;
   logic [CNT_W-1:0]       cnt;
   logic                   accept;
   logic                   fall_nxt;

   assign s        = sync[SYNC_STAGES-1];
   assign accept   = (s != db) && tick && (cnt == CNT_LAST);
   assign rise_nxt = accept && s;
   assign fall_nxt = accept && !s;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         sync <= {SYNC_STAGES{RST_LEVEL}};
      else
         sync <= {sync[SYNC_STAGES-2:0], raw};
   end

   // Equality clears the count even on non-tick clocks.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
         db  <= RST_LEVEL;
      end else if (s == db) begin
         cnt <= '0;
      end else if (tick) begin
         if (cnt == CNT_LAST) begin
            cnt <= '0;
            db  <= s;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rise_p <= 1'b0;
         fall_p <= 1'b0;
      end else begin
         rise_p <= rise_nxt;
         fall_p <= fall_nxt;
      end
   end

   generate
      if (LONG_CYCLES > 0) begin : g_long
         localparam int HW = clog2_min1(LONG_CYCLES + 1);
         localparam logic [HW-1:0] H_MAX = HW'(LONG_CYCLES);
         localparam logic [HW-1:0] H_PRE = HW'(LONG_CYCLES - 1);
         logic [HW-1:0] hold;

         // Saturation at H_MAX gives one pulse per press.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               hold   <= '0;
               long_p <= 1'b0;
            end else begin
               long_p <= db && tick && (hold == H_PRE);
               if (!db)
                  hold <= '0;
               else if (tick && (hold != H_MAX))
                  hold <= hold + 1'b1;
            end
         end
      end else begin : g_nolong
         assign long_p = 1'b0;
      end
   endgenerate

endmodule

// File: rtl/debounce_bank.sv
// Multi-channel debouncer for buttons and door sensors.
// Ports: clk, rst, tick, raw_in -> db_out, rise_p, fall_p, long_p, any_rise.
module debounce_bank
   import debounce_pkg::*;
#(
   parameter int              N_CH        = 8,
   parameter int              DB_CYCLES   = DB_CYCLES_DEF,
   parameter int              SYNC_STAGES = SYNC_STAGES_DEF,
   parameter logic [N_CH-1:0] RST_LEVEL   = {N_CH{1'b0}},
   parameter int              LONG_CYCLES = 0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            tick,
   input  logic [N_CH-1:0] raw_in,
   output logic [N_CH-1:0] db_out,
   output logic [N_CH-1:0] rise_p,
   output logic [N_CH-1:0] fall_p,
   output logic [N_CH-1:0] long_p,
   output logic            any_rise
);

   logic [N_CH-1:0] rise_nxt;

   generate
      for (genvar i = 0; i < N_CH; i++) begin : g_ch
         debounce_ch #(
            .DB_CYCLES   (DB_CYCLES),
            .SYNC_STAGES (SYNC_STAGES),
            .LONG_CYCLES (LONG_CYCLES),
            .RST_LEVEL   (RST_LEVEL[i])
         ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .tick     (tick),
            .raw      (raw_in[i]),
            .db       (db_out[i]),
            .rise_p   (rise_p[i]),
            .fall_p   (fall_p[i]),
            .long_p   (long_p[i]),
            .rise_nxt (rise_nxt[i])
         );
      end
   endgenerate

   // Registered from the same next-state terms as rise_p.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         any_rise <= 1'b0;
      else
         any_rise <= |rise_nxt;
   end

endmodule
